// File: rtl/mem_access_ctrl.sv
// CPU-to-RAM access sequencer: latches a byte/halfword/word request, drives the RAM and extends read data.
// Latency: WAIT_CYCLES+3 edges from req sample to mfc; TIMEOUT+1 ACCESS cycles max before abort.
// Backpressure: req is ignored while busy; MEM_ACCESS_ALIGN_CHECK_EN also rejects misaligned accesses.
module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int TIMEOUT     = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        rw,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [8:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] ram_dout,
    input  logic        ram_done,
    output logic        ram_enable,
    output logic        ram_rw,
    output logic [1:0]  ram_mas,
    output logic [8:0]  ram_addr,
    output logic [1:0]  ram_a,
    output logic [31:0] ram_din,
    output logic [31:0] rdata,
    output logic        mfc,
    output logic        busy,
    output logic        mem_err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t         state_q, state_d;
    logic           rw_q, sx_q;
    logic [1:0]     size_q;
    logic [8:0]     addr_q;
    logic [31:0]    wdata_q;
    logic [31:0]    rdata_q, rdata_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;
    logic           reject, done_ok, timeout;
    logic [31:0]    ext_dat;

    always_comb begin
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        reject = (size_q == 2'b11) ||
                 (size_q == 2'b01 && addr_q[0]) ||
                 (size_q == 2'b10 && addr_q[1:0] != 2'b00);
`else
        reject = (size_q == 2'b11);
`endif
    end

    assign done_ok = (cnt_q >= CW'(WAIT_CYCLES)) && ram_done;
    assign timeout = (cnt_q == CW'(TIMEOUT));

    always_comb begin
        case (size_q)
            2'b00:   ext_dat = {{24{sx_q & ram_dout[7]}},  ram_dout[7:0]};
            2'b01:   ext_dat = {{16{sx_q & ram_dout[15]}}, ram_dout[15:0]};
            default: ext_dat = ram_dout;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rw_q    <= 1'b1;
            sx_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (state_q == IDLE && req) begin
                rw_q    <= rw;
                sx_q    <= sign_ext;
                size_q  <= size;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE:  if (req) state_d = SETUP;
            SETUP: begin
                cnt_d   = '0;
                err_d   = reject;
                state_d = reject ? DONE : ACCESS;
            end
            ACCESS: begin
                // Completion wins over timeout when both land on the same cycle.
                if (done_ok) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                    if (rw_q) rdata_d = ext_dat;
                end else if (timeout) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ram_enable = (state_q == ACCESS);
        busy       = (state_q != IDLE);
        mfc        = (state_q == DONE);
        mem_err    = (state_q == DONE) && err_q;
        ram_rw     = rw_q;
        ram_mas    = size_q;
        ram_addr   = {addr_q[8:2], 2'b00};
        ram_a      = addr_q[1:0];
        ram_din    = wdata_q;
        rdata      = rdata_q;
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed accesses push expectations, a monitor checks each mfc.
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0, rw = 1'b1, sign_ext = 1'b0, ram_done = 1'b1;
    logic [1:0]  size = 2'b00;
    logic [8:0]  addr = '0;
    logic [31:0] wdata = '0, ram_dout = '0;
    logic        ram_enable, ram_rw, mfc, busy, mem_err;
    logic [1:0]  ram_mas, ram_a;
    logic [8:0]  ram_addr;
    logic [31:0] ram_din, rdata;

    mem_access_ctrl dut (
        .clk(clk), .reset_n(reset_n), .req(req), .rw(rw), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .ram_dout(ram_dout),
        .ram_done(ram_done), .ram_enable(ram_enable), .ram_rw(ram_rw),
        .ram_mas(ram_mas), .ram_addr(ram_addr), .ram_a(ram_a), .ram_din(ram_din),
        .rdata(rdata), .mfc(mfc), .busy(busy), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          en;
        int          lat;
        logic [8:0]  ra;
        logic [1:0]  a;
        logic [1:0]  mas;
        logic        rw;
        logic [31:0] din;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic err, input logic [31:0] rd, input int en, input int lat,
                                input logic [8:0] ra, input logic [1:0] a, input logic [1:0] mas,
                                input logic r, input logic [31:0] din);
        exp_t e;
        e.err = err; e.rdata = rd; e.en = en; e.lat = lat; e.ra = ra;
        e.a = a; e.mas = mas; e.rw = r; e.din = din;
        return e;
    endfunction

    // Monitor: measures ram_enable cycles and latency per transaction, checks on every mfc.
    int cyc = 0, setup_cyc = 0, en_cnt = 0;
    bit in_tx = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!busy) in_tx = 0;
        if (reset_n && busy && !in_tx) begin
            in_tx = 1; setup_cyc = cyc; en_cnt = 0;
        end
        if (ram_enable) en_cnt++;
        if (mfc) begin
            if (q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_mfc: got mfc=1 at cycle %0d, required none", cyc);
            end else begin
                e = q.pop_front();
                chk("mem_err",    32'(mem_err),             32'(e.err));
                chk("rdata",      rdata,                    e.rdata);
                chk("en_cycles",  32'(en_cnt),              32'(e.en));
                chk("latency",    32'(cyc - setup_cyc + 1), 32'(e.lat));
                chk("ram_addr",   32'(ram_addr),            32'(e.ra));
                chk("ram_a",      32'(ram_a),               32'(e.a));
                chk("ram_mas",    32'(ram_mas),             32'(e.mas));
                chk("ram_rw",     32'(ram_rw),              32'(e.rw));
                chk("ram_din",    ram_din,                  e.din);
            end
        end
        cyc++;
    end

    task automatic wait_idle(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < 100);
        if (busy) begin
            n_chk++; n_fail++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, k);
        end
    endtask

    task automatic issue(input logic r, input logic [1:0] s, input logic sx, input logic [8:0] a,
                         input logic [31:0] wd, input exp_t e);
        q.push_back(e);
        @(negedge clk);
        rw = r; size = s; sign_ext = sx; addr = a; wdata = wd; req = 1'b1;
        @(posedge clk);
        #1;
        // Scramble inputs after the sampling edge; the access must use the latched copy.
        req = 1'b0; rw = ~r; size = 2'b11; sign_ext = ~sx; addr = ~a; wdata = ~wd;
        wait_idle("issue");
    endtask

    initial begin
        logic [31:0] last;
        int k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",     32'(busy),       32'd0);
        chk("rst_ram_en",   32'(ram_enable), 32'd0);
        chk("rst_mfc",      32'(mfc),        32'd0);
        chk("rst_mem_err",  32'(mem_err),    32'd0);
        chk("rst_rdata",    rdata,           32'd0);
        chk("rst_ram_addr", 32'(ram_addr),   32'd0);
        chk("rst_ram_a",    32'(ram_a),      32'd0);
        chk("rst_ram_mas",  32'(ram_mas),    32'd0);
        chk("rst_ram_din",  ram_din,         32'd0);
        chk("rst_ram_rw",   32'(ram_rw),     32'd1);
        reset_n = 1'b1;

        ram_done = 1'b1;
        issue(1'b0, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF,
              mk(1'b0, 32'h0, 3, 5, 9'h010, 2'd0, 2'b10, 1'b0, 32'hDEADBEEF));
        ram_dout = 32'h00000080;
        issue(1'b1, 2'b00, 1'b1, 9'h005, 32'h0,
              mk(1'b0, 32'hFFFFFF80, 3, 5, 9'h004, 2'd1, 2'b00, 1'b1, 32'h0));
        issue(1'b1, 2'b00, 1'b0, 9'h005, 32'h0,
              mk(1'b0, 32'h00000080, 3, 5, 9'h004, 2'd1, 2'b00, 1'b1, 32'h0));
        ram_dout = 32'h00008001;
        issue(1'b1, 2'b01, 1'b1, 9'h022, 32'h0,
              mk(1'b0, 32'hFFFF8001, 3, 5, 9'h020, 2'd2, 2'b01, 1'b1, 32'h0));
        ram_dout = 32'hFFFF8001;
        issue(1'b1, 2'b01, 1'b0, 9'h022, 32'h0,
              mk(1'b0, 32'h00008001, 3, 5, 9'h020, 2'd2, 2'b01, 1'b1, 32'h0));
        ram_dout = 32'h0000007F;
        issue(1'b1, 2'b00, 1'b1, 9'h003, 32'h0,
              mk(1'b0, 32'h0000007F, 3, 5, 9'h000, 2'd3, 2'b00, 1'b1, 32'h0));
        ram_dout = 32'h12345678;
        issue(1'b1, 2'b10, 1'b1, 9'h1FC, 32'h0,
              mk(1'b0, 32'h12345678, 3, 5, 9'h1FC, 2'd0, 2'b10, 1'b1, 32'h0));

        // Timeout: 16 ACCESS cycles, rdata keeps the previous load.
        ram_done = 1'b0; ram_dout = 32'hFFFFFFFF;
        issue(1'b1, 2'b10, 1'b0, 9'h040, 32'h0,
              mk(1'b1, 32'h12345678, 16, 18, 9'h040, 2'd0, 2'b10, 1'b1, 32'h0));
        ram_done = 1'b1;
        issue(1'b1, 2'b11, 1'b0, 9'h008, 32'h11,
              mk(1'b1, 32'h12345678, 0, 2, 9'h008, 2'd0, 2'b11, 1'b1, 32'h11));

        ram_dout = 32'hA5A5A5A5;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        issue(1'b1, 2'b10, 1'b0, 9'h003, 32'h0,
              mk(1'b1, 32'h12345678, 0, 2, 9'h000, 2'd3, 2'b10, 1'b1, 32'h0));
        last = 32'h12345678;
`else
        issue(1'b1, 2'b10, 1'b0, 9'h003, 32'h0,
              mk(1'b0, 32'hA5A5A5A5, 3, 5, 9'h000, 2'd3, 2'b10, 1'b1, 32'h0));
        last = 32'hA5A5A5A5;
`endif

        // req held high through DONE: exactly two back-to-back accesses with one IDLE gap.
        q.push_back(mk(1'b0, last, 3, 5, 9'h0AC, 2'd2, 2'b01, 1'b0, 32'h0000BEEF));
        q.push_back(mk(1'b0, last, 3, 5, 9'h0AC, 2'd2, 2'b01, 1'b0, 32'h0000BEEF));
        @(negedge clk);
        rw = 1'b0; size = 2'b01; sign_ext = 1'b0; addr = 9'h0AE; wdata = 32'h0000BEEF; req = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!mfc && k < 50);
        @(negedge clk);
        chk("b2b_idle_gap", 32'(busy), 32'd0);
        @(posedge clk);
        #1 req = 1'b0;
        wait_idle("b2b");

        // Reset during ACCESS aborts with no mfc.
        ram_done = 1'b0;
        @(negedge clk);
        rw = 1'b1; size = 2'b10; addr = 9'h100; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ram_enable && k < 10);
        chk("abort_in_access", 32'(ram_enable), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy",   32'(busy),       32'd0);
        chk("abort_ram_en", 32'(ram_enable), 32'd0);
        chk("abort_mfc",    32'(mfc),        32'd0);
        chk("abort_rdata",  rdata,           32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        ram_done = 1'b1; ram_dout = 32'h000000FF;
        issue(1'b1, 2'b00, 1'b1, 9'h1FF, 32'h0,
              mk(1'b0, 32'hFFFFFFFF, 3, 5, 9'h1FC, 2'd3, 2'b00, 1'b1, 32'h0));

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
